ctrl_fsm_mc: RTL and testbench
==============================

Name: ctrl_fsm_mc

Overview:
Multicycle control unit that replaces the combinational opcode decoder for the multicycle datapath. It fetches an instruction through a valid/ready handshake, latches the opcode, and sequences FETCH/DECODE/EXEC/MEM/WB/BRANCH. Mult/div get a programmable number of execute cycles. Memory accesses are stretched until mem_ready. Outputs drive the existing datapath muxes, register file, flag register and data memory.

Parameters:
OPCODE_W, 4, opcode width (>=4); any nonzero bit above [3:0] makes the opcode illegal
ALUCTL_W, 2, alu_control width (>=2); the 2-bit ALU codes are zero-extended
MULDIV_CYCLES, 4, EXEC cycles for opcodes 0000-0011 (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  instruction word available
instr_ready  out  1  unit accepts opcode this cycle
opcode  in  OPCODE_W  opcode of the offered instruction
flag_z  in  1  registered zero flag from the flag register
mem_ready  in  1  data memory completes the access this cycle
ir_write  out  1  latch the instruction register
pc_write  out  1  update PC
pc_src  out  1  0=PC+1, 1=branch target
reg_write  out  1  register-file write enable
alu_src  out  1  0=register operand, 1=immediate
imm_src  out  1  0=ext[7:0], 1=ext[11:0]
ra1_src  out  1  read-address-1 mux select
ra2_src  out  1  read-address-2 mux select
alu_control  out  ALUCTL_W  00 add, 01 mul, 10 div, 11 compare
flag_update  out  1  flag-register enable
mem_to_reg  out  1  1=ALU result, 0=memory data
mem_read  out  1  data memory read request
mem_write  out  1  data memory write request
illegal_op  out  1  one-cycle pulse on an undefined opcode
busy  out  1  high in every state except FETCH

Behaviour:
- Reset (async, rst_n=0): state=FETCH, op_q=0, counter=0, every output 0. Reset mid-operation abandons the instruction with no write of any kind. The first rising edge after release runs FETCH.
- Outputs are Moore: a function of state and op_q only. Any enable not listed for a state is 0 in that state.
- FETCH: instr_ready=1. On instr_valid, ir_write=1 in the same cycle, op_q<=opcode, next state is DECODE. Otherwise stay in FETCH.
- DECODE: one cycle, no enables.
  - Legal opcodes: 0000-1000 and 1111, with upper bits zero. These go to EXEC and load counter=MULDIV_CYCLES-1.
  - Any other opcode: illegal_op=1, pc_write=1, pc_src=0 (skip), next state FETCH.
- EXEC: alu_control, alu_src, imm_src, ra1_src and ra2_src are driven per opcode. Values match the existing decoder:
  - mul 0000/0001: ctl 01, alu_src=op[0]
  - div 0010/0011: ctl 10, alu_src=op[0]
  - add 0100: ctl 00, alu_src=0
  - addi 1111: ctl 00, alu_src=1
  - ld 0101: ctl 00, alu_src=1, imm_src=1
  - st 0110: ctl 00, alu_src=1, imm_src=1, ra2_src=1
  - b 0111: ctl 00, alu_src=1, ra1_src=1, ra2_src=1
  - beq 1000: ctl 11, alu_src=0
- EXEC timing and flags:
  - Mul/div stay in EXEC while counter!=0, decrementing each cycle, for MULDIV_CYCLES cycles in total. All other opcodes spend 1 cycle.
  - flag_update=1 only in the last EXEC cycle, for every opcode except st and b.
- EXEC exit:
  - ALU ops go to WB. ld and st go to MEM.
  - b: pc_write=1, pc_src=1 in its EXEC cycle, then FETCH.
  - beq goes to BRANCH.
- MEM: address controls are held from EXEC.
  - ld: mem_read=1. st: mem_write=1.
  - Held until the cycle mem_ready=1, which completes the access.
  - ld then goes to WB.
  - st: pc_write=1 in its completing cycle, then FETCH.
  - mem_ready outside MEM is ignored.
- BRANCH: pc_write=1, pc_src=flag_z (sampled this cycle), then FETCH.
- WB: one cycle, then FETCH.
  - reg_write=1, pc_write=1, pc_src=0.
  - mem_to_reg=0 for ld, 1 for the others.
- Latency in cycles, FETCH with valid to next FETCH:
  - add/addi: 4
  - mul/div: 3+MULDIV_CYCLES
  - ld: 5+wait; st: 4+wait (wait = extra MEM cycles before mem_ready)
  - b: 3
  - beq: 4
  - illegal: 2
- Exactly one pc_write pulse is issued per accepted instruction. instr_ready is never high outside FETCH.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with instr_valid=1 -> all outputs 0. After release: instr_ready=1, ir_write=1 on the first edge.
- add (0100): -> EXEC ctl=00, alu_src=0, flag_update=1; WB reg_write=1, mem_to_reg=1, pc_write=1; back in FETCH after 4 cycles.
- mul-imm (0001) with MULDIV_CYCLES=4: -> ctl=01 and alu_src=1 for 4 EXEC cycles; flag_update only in the 4th; reg_write at cycle 7.
- ld (0101) with mem_ready low for 2 MEM cycles: -> mem_read high for 3 cycles, imm_src=1; then WB with mem_to_reg=0 and reg_write=1; total 7 cycles.
- beq (1000) with flag_z=1, then with flag_z=0: -> BRANCH pc_write=1, pc_src=1, then pc_src=0; reg_write never asserted.
- Illegal opcode 1010, and rst_n pulsed low during a st MEM wait: -> illegal_op single pulse plus skip. On reset: mem_write drops asynchronously and state returns to FETCH.

Source files
------------

// File: rtl/ctrl_fsm_mc.sv
// Multicycle control unit: handshaked fetch, opcode latch, and FETCH/DECODE/EXEC/MEM/WB/BRANCH
// sequencing that drives the datapath muxes, register file, flag register and data memory.
module ctrl_fsm_mc #(
  parameter int OPCODE_W      = 4,
  parameter int ALUCTL_W      = 2,
  parameter int MULDIV_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                flag_z,
  input  logic                mem_ready,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_src,
  output logic                reg_write,
  output logic                alu_src,
  output logic                imm_src,
  output logic                ra1_src,
  output logic                ra2_src,
  output logic [ALUCTL_W-1:0] alu_control,
  output logic                flag_update,
  output logic                mem_to_reg,
  output logic                mem_read,
  output logic                mem_write,
  output logic                illegal_op,
  output logic                busy
);

  localparam int CNT_W = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_BRANCH = 3'd5
  } state_t;

  state_t              state_r;
  state_t              next_state_s;
  logic [OPCODE_W-1:0] op_r;
  logic [CNT_W-1:0]    cnt_r;

  logic [3:0] op_lo_s;
  logic       muldiv_s;
  logic       last_exec_s;
  logic [1:0] dec_ctl_s;
  logic       dec_alu_src_s;
  logic       dec_imm_src_s;
  logic       dec_ra1_src_s;
  logic       dec_ra2_src_s;

  // Defined opcodes are 0000-1000 and 1111 with every bit above [3:0] clear.
  function automatic logic op_legal(input logic [OPCODE_W-1:0] op);
    logic upper_zero;
    upper_zero = ((op >> 32'd4) == {OPCODE_W{1'b0}});
    op_legal   = upper_zero && ((op[3:0] <= 4'd8) || (op[3:0] == 4'hF));
  endfunction

  assign op_lo_s     = op_r[3:0];
  assign muldiv_s    = (op_lo_s[3:2] == 2'b00);
  assign last_exec_s = !muldiv_s || (cnt_r == {CNT_W{1'b0}});

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Opcode latch on an accepted fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r <= {OPCODE_W{1'b0}};
    end else if ((state_r == ST_FETCH) && instr_valid) begin
      op_r <= opcode;
    end else begin
      op_r <= op_r;
    end
  end

  // Execute-cycle counter: loaded in DECODE, counts down only for mul/div.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == ST_DECODE) && op_legal(op_r)) begin
      cnt_r <= CNT_W'(MULDIV_CYCLES - 1);
    end else if ((state_r == ST_EXEC) && muldiv_s && (cnt_r != {CNT_W{1'b0}})) begin
      cnt_r <= cnt_r - CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Per-opcode ALU and operand-mux settings, shared by EXEC and MEM.
  always_comb begin
    dec_ctl_s     = 2'b00;
    dec_alu_src_s = 1'b0;
    dec_imm_src_s = 1'b0;
    dec_ra1_src_s = 1'b0;
    dec_ra2_src_s = 1'b0;
    case (op_lo_s)
      4'h0, 4'h1: begin
        dec_ctl_s     = 2'b01;
        dec_alu_src_s = op_lo_s[0];
      end
      4'h2, 4'h3: begin
        dec_ctl_s     = 2'b10;
        dec_alu_src_s = op_lo_s[0];
      end
      4'h5: begin
        dec_alu_src_s = 1'b1;
        dec_imm_src_s = 1'b1;
      end
      4'h6: begin
        dec_alu_src_s = 1'b1;
        dec_imm_src_s = 1'b1;
        dec_ra2_src_s = 1'b1;
      end
      4'h7: begin
        dec_alu_src_s = 1'b1;
        dec_ra1_src_s = 1'b1;
        dec_ra2_src_s = 1'b1;
      end
      4'h8: begin
        dec_ctl_s = 2'b11;
      end
      4'hF: begin
        dec_alu_src_s = 1'b1;
      end
      default: begin
        dec_ctl_s = 2'b00;
      end
    endcase
  end

  // Next-state and output decode; everything is held low while reset is asserted.
  always_comb begin
    next_state_s = state_r;
    instr_ready  = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    reg_write    = 1'b0;
    alu_src      = 1'b0;
    imm_src      = 1'b0;
    ra1_src      = 1'b0;
    ra2_src      = 1'b0;
    alu_control  = {ALUCTL_W{1'b0}};
    flag_update  = 1'b0;
    mem_to_reg   = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    illegal_op   = 1'b0;
    busy         = 1'b0;
    if (!rst_n) begin
      next_state_s = ST_FETCH;
    end else begin
      case (state_r)
        ST_FETCH: begin
          instr_ready = 1'b1;
          if (instr_valid) begin
            ir_write     = 1'b1;
            next_state_s = ST_DECODE;
          end else begin
            next_state_s = ST_FETCH;
          end
        end
        ST_DECODE: begin
          busy = 1'b1;
          if (op_legal(op_r)) begin
            next_state_s = ST_EXEC;
          end else begin
            illegal_op   = 1'b1;
            pc_write     = 1'b1;
            next_state_s = ST_FETCH;
          end
        end
        ST_EXEC: begin
          busy        = 1'b1;
          alu_control = ALUCTL_W'(dec_ctl_s);
          alu_src     = dec_alu_src_s;
          imm_src     = dec_imm_src_s;
          ra1_src     = dec_ra1_src_s;
          ra2_src     = dec_ra2_src_s;
          flag_update = last_exec_s && (op_lo_s != 4'h6) && (op_lo_s != 4'h7);
          if (!last_exec_s) begin
            next_state_s = ST_EXEC;
          end else begin
            case (op_lo_s)
              4'h5, 4'h6: next_state_s = ST_MEM;
              4'h7: begin
                pc_write     = 1'b1;
                pc_src       = 1'b1;
                next_state_s = ST_FETCH;
              end
              4'h8:    next_state_s = ST_BRANCH;
              default: next_state_s = ST_WB;
            endcase
          end
        end
        ST_MEM: begin
          busy        = 1'b1;
          alu_control = ALUCTL_W'(dec_ctl_s);
          alu_src     = dec_alu_src_s;
          imm_src     = dec_imm_src_s;
          ra1_src     = dec_ra1_src_s;
          ra2_src     = dec_ra2_src_s;
          if (op_lo_s == 4'h5) begin
            mem_read = 1'b1;
          end else begin
            mem_write = 1'b1;
          end
          if (!mem_ready) begin
            next_state_s = ST_MEM;
          end else if (op_lo_s == 4'h5) begin
            next_state_s = ST_WB;
          end else begin
            pc_write     = 1'b1;
            next_state_s = ST_FETCH;
          end
        end
        ST_BRANCH: begin
          busy         = 1'b1;
          pc_write     = 1'b1;
          pc_src       = flag_z;
          next_state_s = ST_FETCH;
        end
        ST_WB: begin
          busy         = 1'b1;
          reg_write    = 1'b1;
          pc_write     = 1'b1;
          mem_to_reg   = (op_lo_s != 4'h5);
          next_state_s = ST_FETCH;
        end
        default: begin
          next_state_s = ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_fsm_mc.sv
// Directed bench for ctrl_fsm_mc: one linear sequence of steps, each output snapshot checked
// against a hand-built expected vector with an immediate assertion.
module tb_ctrl_fsm_mc;

  logic       clk;
  logic       rst_n;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] opcode;
  logic       flag_z;
  logic       mem_ready;
  logic       ir_write, pc_write, pc_src, reg_write, alu_src, imm_src;
  logic       ra1_src, ra2_src, flag_update, mem_to_reg, mem_read, mem_write;
  logic       illegal_op, busy;
  logic [1:0] alu_control;

  int cmps;
  int errs;

  // Output snapshot bit positions.
  localparam logic [16:0] RDY   = 17'h10000;
  localparam logic [16:0] IRW   = 17'h08000;
  localparam logic [16:0] PCW   = 17'h04000;
  localparam logic [16:0] PCS   = 17'h02000;
  localparam logic [16:0] RW    = 17'h01000;
  localparam logic [16:0] AS    = 17'h00800;
  localparam logic [16:0] IS    = 17'h00400;
  localparam logic [16:0] R1    = 17'h00200;
  localparam logic [16:0] R2    = 17'h00100;
  localparam logic [16:0] C_MUL = 17'h00040;
  localparam logic [16:0] C_CMP = 17'h000C0;
  localparam logic [16:0] FU    = 17'h00020;
  localparam logic [16:0] MTR   = 17'h00010;
  localparam logic [16:0] MR    = 17'h00008;
  localparam logic [16:0] MW    = 17'h00004;
  localparam logic [16:0] ILL   = 17'h00002;
  localparam logic [16:0] BSY   = 17'h00001;
  localparam logic [16:0] NONE  = 17'h00000;

  logic [16:0] outs;
  assign outs = {instr_ready, ir_write, pc_write, pc_src, reg_write, alu_src, imm_src,
                 ra1_src, ra2_src, alu_control, flag_update, mem_to_reg, mem_read,
                 mem_write, illegal_op, busy};

  ctrl_fsm_mc #(.OPCODE_W(4), .ALUCTL_W(2), .MULDIV_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opcode      (opcode),
    .flag_z      (flag_z),
    .mem_ready   (mem_ready),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .reg_write   (reg_write),
    .alu_src     (alu_src),
    .imm_src     (imm_src),
    .ra1_src     (ra1_src),
    .ra2_src     (ra2_src),
    .alu_control (alu_control),
    .flag_update (flag_update),
    .mem_to_reg  (mem_to_reg),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .illegal_op  (illegal_op),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [16:0] exp);
    #1;
    cmps++;
    assert (outs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %05h expected %05h", tag, outs, exp);
    end
  endtask

  initial begin
    cmps        = 0;
    errs        = 0;
    rst_n       = 1'b0;
    instr_valid = 1'b1;
    opcode      = 4'h4;
    flag_z      = 1'b0;
    mem_ready   = 1'b0;

    // Reset held for three edges with a valid instruction offered.
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("reset_hold", NONE);
    end
    rst_n = 1'b1;
    chk("fetch_after_release", RDY | IRW);

    // add 0100: latency 4.
    cyc(); instr_valid = 1'b0; opcode = 4'hA;
    chk("add_decode", BSY);
    cyc(); chk("add_exec", BSY | FU);
    cyc(); chk("add_wb", BSY | RW | MTR | PCW);
    cyc(); chk("add_fetch_idle", RDY);

    // mul-imm 0001: four EXEC cycles, flag update only in the last.
    instr_valid = 1'b1; opcode = 4'h1;
    chk("mul_accept", RDY | IRW);
    cyc(); instr_valid = 1'b0; opcode = 4'h6;
    chk("mul_decode", BSY);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("mul_exec", (i == 3) ? (BSY | C_MUL | AS | FU) : (BSY | C_MUL | AS));
    end
    cyc(); chk("mul_wb_cycle7", BSY | RW | MTR | PCW);
    cyc(); chk("mul_fetch", RDY);

    // ld 0101 with two wait cycles: total 7.
    instr_valid = 1'b1; opcode = 4'h5;
    chk("ld_accept", RDY | IRW);
    cyc(); instr_valid = 1'b0;
    chk("ld_decode", BSY);
    cyc(); chk("ld_exec", BSY | AS | IS | FU);
    cyc(); chk("ld_mem_wait1", BSY | AS | IS | MR);
    cyc(); chk("ld_mem_wait2", BSY | AS | IS | MR);
    cyc(); mem_ready = 1'b1;
    chk("ld_mem_done", BSY | AS | IS | MR);
    cyc(); mem_ready = 1'b0;
    chk("ld_wb", BSY | RW | PCW);
    cyc(); chk("ld_fetch", RDY);

    // beq 1000 taken.
    instr_valid = 1'b1; opcode = 4'h8;
    chk("beq1_accept", RDY | IRW);
    cyc(); instr_valid = 1'b0;
    chk("beq1_decode", BSY);
    cyc(); chk("beq1_exec", BSY | C_CMP | FU);
    cyc(); flag_z = 1'b1;
    chk("beq1_branch_taken", BSY | PCW | PCS);
    cyc(); flag_z = 1'b0;
    chk("beq1_fetch", RDY);

    // beq 1000 not taken.
    instr_valid = 1'b1; opcode = 4'h8;
    cyc(); instr_valid = 1'b0;
    chk("beq0_decode", BSY);
    cyc(); chk("beq0_exec", BSY | C_CMP | FU);
    cyc(); chk("beq0_branch_not_taken", BSY | PCW);
    cyc(); chk("beq0_fetch", RDY);

    // b 0111: latency 3, pc redirected in EXEC.
    instr_valid = 1'b1; opcode = 4'h7;
    cyc(); instr_valid = 1'b0;
    chk("b_decode", BSY);
    cyc(); chk("b_exec", BSY | AS | R1 | R2 | PCW | PCS);
    cyc(); chk("b_fetch", RDY);

    // addi 1111.
    instr_valid = 1'b1; opcode = 4'hF;
    cyc(); instr_valid = 1'b0;
    chk("addi_decode", BSY);
    cyc(); chk("addi_exec", BSY | AS | FU);
    cyc(); chk("addi_wb", BSY | RW | MTR | PCW);
    cyc(); chk("addi_fetch", RDY);

    // Illegal 1010: single-cycle pulse plus skip.
    instr_valid = 1'b1; opcode = 4'hA;
    cyc(); instr_valid = 1'b0;
    chk("illegal_decode", BSY | ILL | PCW);
    cyc(); chk("illegal_fetch", RDY);

    // st 0110 completing at once; mem_ready high early must be ignored.
    instr_valid = 1'b1; opcode = 4'h6; mem_ready = 1'b1;
    cyc(); instr_valid = 1'b0;
    chk("st_decode", BSY);
    cyc(); chk("st_exec", BSY | AS | IS | R2);
    cyc(); chk("st_mem_done", BSY | AS | IS | R2 | MW | PCW);
    cyc(); mem_ready = 1'b0;
    chk("st_fetch", RDY);

    // st 0110 abandoned by an asynchronous reset during its MEM wait.
    instr_valid = 1'b1; opcode = 4'h6;
    cyc(); instr_valid = 1'b0;
    cyc(); chk("st2_exec", BSY | AS | IS | R2);
    cyc(); chk("st2_mem_wait", BSY | AS | IS | R2 | MW);
    rst_n = 1'b0;
    chk("st2_async_reset", NONE);
    rst_n = 1'b1;
    chk("st2_back_in_fetch", RDY);
    cyc(); chk("st2_fetch_stays", RDY);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule
